// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load-use stall, branch flush, memory-wait freeze and handshake watchdog.
// Define HAZARD_PERF_EN to build the stallCycles/flushCount performance counters.
module hazard_ctrl #(
    parameter int REG_SIZE    = 5,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REG_SIZE-1:0] rs1D,
    input  logic [REG_SIZE-1:0] rs2D,
    input  logic                useRs1D,
    input  logic                useRs2D,
    input  logic                validD,
    input  logic [REG_SIZE-1:0] rs1E,
    input  logic [REG_SIZE-1:0] rs2E,
    input  logic [REG_SIZE-1:0] writeRegE,
    input  logic                regWriteE,
    input  logic                mem2regE,
    input  logic                validE,
    input  logic [REG_SIZE-1:0] writeRegM,
    input  logic                regWriteM,
    input  logic                mem2regM,
    input  logic                validM,
    input  logic [REG_SIZE-1:0] writeRegW,
    input  logic                regWriteW,
    input  logic                validW,
    input  logic                PCSrcM,
    input  logic                memReqM,
    input  logic                memReadyM,
    output logic [1:0]          forwardAE,
    output logic [1:0]          forwardBE,
    output logic                stallF,
    output logic                stallD,
    output logic                stallE,
    output logic                stallM,
    output logic                flushD,
    output logic                flushE,
    output logic                flushM,
    output logic                flushW,
    output logic [1:0]          state,
    output logic                memErr,
    output logic [31:0]         stallCycles,
    output logic [31:0]         flushCount
);
    localparam logic [1:0] RUN      = 2'b00;
    localparam logic [1:0] MEM_WAIT = 2'b01;
    localparam logic [1:0] FLUSH    = 2'b10;
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    logic [1:0]       stateNext;
    logic [CNT_W-1:0] waitCnt;
    logic [CNT_W-1:0] waitNext;
    logic             mSrcOk;
    logic             wSrcOk;
    logic             loadUse;
    logic             pcFlush;
    logic             memStall;
    logic             luStall;

    // Loads in M have no data yet, so only ALU results forward from M
    assign mSrcOk = validM & regWriteM & ~mem2regM & (writeRegM != '0);
    assign wSrcOk = validW & regWriteW & (writeRegW != '0);

    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (reset) begin
            forwardAE = (mSrcOk & (writeRegM == rs1E)) ? 2'b10 : (wSrcOk & (writeRegW == rs1E)) ? 2'b01 : 2'b00;
            forwardBE = (mSrcOk & (writeRegM == rs2E)) ? 2'b10 : (wSrcOk & (writeRegW == rs2E)) ? 2'b01 : 2'b00;
        end
    end

    assign loadUse = validE & regWriteE & mem2regE & (writeRegE != '0) & validD &
                     ((useRs1D & (rs1D == writeRegE)) | (useRs2D & (rs2D == writeRegE)));

    // A wait releases in the cycle memReadyM arrives so the access completes without an extra bubble
    assign pcFlush  = PCSrcM & (state != MEM_WAIT);
    assign memStall = ~memReadyM & ((state == MEM_WAIT) | ((state == RUN) & memReqM & ~PCSrcM));
    assign luStall  = loadUse & ~pcFlush & ~memStall;

    assign stallF = reset & (memStall | luStall);
    assign stallD = reset & (memStall | luStall);
    assign stallE = reset & memStall;
    assign stallM = reset & memStall;
    assign flushD = reset & pcFlush;
    assign flushE = reset & (pcFlush | luStall);
    assign flushM = reset & pcFlush;
    assign flushW = reset & memStall;

    always_comb begin
        stateNext = RUN;
        if (state == RUN)
            stateNext = PCSrcM ? FLUSH : (memReqM & ~memReadyM) ? MEM_WAIT : RUN;
        else if (state == MEM_WAIT)
            stateNext = memReadyM ? RUN : MEM_WAIT;
    end

    assign waitNext = (waitCnt == CNT_MAX) ? waitCnt : waitCnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            waitCnt <= '0;
            memErr  <= 1'b0;
        end else begin
            state   <= stateNext;
            waitCnt <= ((state == MEM_WAIT) & ~memReadyM) ? waitNext : '0;
            memErr  <= memErr | ((state == MEM_WAIT) & ~memReadyM & (waitNext == CNT_MAX));
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCycles <= '0;
            flushCount  <= '0;
        end else begin
            if (stallF) stallCycles <= stallCycles + 32'd1;
            if (PCSrcM) flushCount <= flushCount + 32'd1;
        end
    end
`else
    assign stallCycles = '0;
    assign flushCount  = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus randomized traffic against a rule-level reference model.
module tb_hazard_ctrl;
    localparam int RS = 5;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [RS-1:0] rs1D, rs2D, rs1E, rs2E, writeRegE, writeRegM, writeRegW;
    logic useRs1D, useRs2D, validD, regWriteE, mem2regE, validE;
    logic regWriteM, mem2regM, validM, regWriteW, validW, PCSrcM, memReqM, memReadyM;
    logic [1:0] forwardAE, forwardBE, state;
    logic stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, memErr;
    logic [31:0] stallCycles, flushCount;
    logic [14:0] dutOut;
    logic [7:0] ctl;

    int checks = 0;
    int errors = 0;

    bit mWaiting = 0;
    bit mAfterBranch = 0;
    bit mErr = 0;
    int mWaitLen = 0;
    logic [31:0] mStalls = '0;
    logic [31:0] mFlushes = '0;

    hazard_ctrl #(.REG_SIZE(RS), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .rs1D(rs1D), .rs2D(rs2D), .useRs1D(useRs1D), .useRs2D(useRs2D), .validD(validD),
        .rs1E(rs1E), .rs2E(rs2E),
        .writeRegE(writeRegE), .regWriteE(regWriteE), .mem2regE(mem2regE), .validE(validE),
        .writeRegM(writeRegM), .regWriteM(regWriteM), .mem2regM(mem2regM), .validM(validM),
        .writeRegW(writeRegW), .regWriteW(regWriteW), .validW(validW),
        .PCSrcM(PCSrcM), .memReqM(memReqM), .memReadyM(memReadyM),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .state(state), .memErr(memErr), .stallCycles(stallCycles), .flushCount(flushCount)
    );

    always #5 clk = ~clk;

    assign dutOut = {forwardAE, forwardBE, stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, state, memErr};
    assign ctl = {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW};

    function automatic logic [1:0] fwdPick(input logic [RS-1:0] src);
        if (validM && regWriteM && !mem2regM && writeRegM != 0 && writeRegM == src) return 2'b10;
        if (validW && regWriteW && writeRegW != 0 && writeRegW == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit branchFlush();
        return PCSrcM && !mWaiting;
    endfunction

    function automatic bit memHold();
        return !memReadyM && (mWaiting || (!mAfterBranch && memReqM && !PCSrcM));
    endfunction

    function automatic bit hazardLU();
        bit dep;
        dep = validD && ((useRs1D && rs1D == writeRegE) || (useRs2D && rs2D == writeRegE));
        return validE && regWriteE && mem2regE && writeRegE != 0 && dep && !branchFlush() && !memHold();
    endfunction

    function automatic logic [14:0] expOut();
        bit h, b, l;
        logic [1:0] st;
        if (!reset) return 15'd0;
        h = memHold();
        b = branchFlush();
        l = hazardLU();
        st = mWaiting ? 2'd1 : mAfterBranch ? 2'd2 : 2'd0;
        return {fwdPick(rs1E), fwdPick(rs2E), h | l, h | l, h, h, b, b | l, b, h, st, mErr};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mWaiting <= 0;
            mAfterBranch <= 0;
            mWaitLen <= 0;
            mErr <= 0;
            mStalls <= '0;
            mFlushes <= '0;
        end else begin
            if (memHold() || hazardLU()) mStalls <= mStalls + 1;
            if (PCSrcM) mFlushes <= mFlushes + 1;
            if (mWaiting) begin
                if (memReadyM) begin
                    mWaiting <= 0;
                    mWaitLen <= 0;
                end else begin
                    mWaitLen <= (mWaitLen + 1 > TO) ? TO : mWaitLen + 1;
                    if (mWaitLen + 1 >= TO) mErr <= 1;
                end
            end else if (mAfterBranch) mAfterBranch <= 0;
            else if (PCSrcM) mAfterBranch <= 1;
            else if (memReqM && !memReadyM) mWaiting <= 1;
        end
    end

    task automatic clearIn();
        {rs1D, rs2D, rs1E, rs2E, writeRegE, writeRegM, writeRegW} = '0;
        {useRs1D, useRs2D, validD, regWriteE, mem2regE, validE} = '0;
        {regWriteM, mem2regM, validM, regWriteW, validW, PCSrcM, memReqM, memReadyM} = '0;
    endtask

    task automatic setLoadUse();
        validE = 1; regWriteE = 1; mem2regE = 1; writeRegE = 6;
        validD = 1; useRs2D = 1; rs2D = 6; useRs1D = 1; rs1D = 1;
    endtask

    task automatic resetPulse();
        @(negedge clk);
        reset = 0;
        clearIn();
        @(negedge clk);
        reset = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        setLoadUse();
        PCSrcM = 1; memReqM = 1;
        validM = 1; regWriteM = 1; writeRegM = 3; rs1E = 3;
        #2;
        checks++;
        if (dutOut !== 15'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", dutOut); end
        checks++;
        if (stallCycles !== 0 || flushCount !== 0) begin errors++; $display("FAIL reset_counters: got %h/%h expected 0/0", stallCycles, flushCount); end
        @(negedge clk);
        clearIn();
        reset = 1;
    endtask

    task automatic test_forwarding();
        @(negedge clk); clearIn();
        validM = 1; regWriteM = 1; writeRegM = 5; rs1E = 5; rs2E = 3; #2;
        checks++;
        if ({forwardAE, forwardBE} !== 4'b1000) begin errors++; $display("FAIL fwd_from_M: got %b expected 1000", {forwardAE, forwardBE}); end
        @(negedge clk); clearIn();
        validW = 1; regWriteW = 1; writeRegW = 5; rs1E = 5; #2;
        checks++;
        if (forwardAE !== 2'b01) begin errors++; $display("FAIL fwd_from_W: got %b expected 01", forwardAE); end
        @(negedge clk);
        validM = 1; regWriteM = 1; writeRegM = 5; #2;
        checks++;
        if (forwardAE !== 2'b10) begin errors++; $display("FAIL fwd_M_priority: got %b expected 10", forwardAE); end
        @(negedge clk);
        mem2regM = 1; #2;
        checks++;
        if (forwardAE !== 2'b01) begin errors++; $display("FAIL fwd_load_in_M: got %b expected 01", forwardAE); end
        @(negedge clk); clearIn();
        validM = 1; regWriteM = 1; validW = 1; regWriteW = 1; #2;
        checks++;
        if ({forwardAE, forwardBE} !== 4'b0000) begin errors++; $display("FAIL fwd_x0: got %b expected 0000", {forwardAE, forwardBE}); end
        @(negedge clk); clearIn();
        validM = 1; regWriteM = 1; writeRegM = 7; rs2E = 7; rs1E = 2; #2;
        checks++;
        if ({forwardAE, forwardBE} !== 4'b0010) begin errors++; $display("FAIL fwd_B_from_M: got %b expected 0010", {forwardAE, forwardBE}); end
    endtask

    task automatic test_load_use();
        @(negedge clk); clearIn();
        setLoadUse(); #2;
        checks++;
        if (ctl !== 8'b1100_0100) begin errors++; $display("FAIL loaduse_stall: got %b expected 11000100", ctl); end
        @(negedge clk);
        validE = 0; regWriteE = 0; mem2regE = 0;
        validM = 1; regWriteM = 1; mem2regM = 1; writeRegM = 6; rs2E = 0; #2;
        checks++;
        if ({ctl, forwardBE} !== 10'd0) begin errors++; $display("FAIL loaduse_release: got %b expected 0", {ctl, forwardBE}); end
        @(negedge clk);
        validM = 0; regWriteM = 0; mem2regM = 0;
        validW = 1; regWriteW = 1; writeRegW = 6; rs2E = 6; rs1E = 1; validD = 0; #2;
        checks++;
        if ({ctl, forwardBE} !== 10'b00000000_01) begin errors++; $display("FAIL loaduse_consumer_fwd: got %b expected 0000000001", {ctl, forwardBE}); end
        @(negedge clk); clearIn();
        setLoadUse(); useRs2D = 0; #2;
        checks++;
        if (ctl !== 8'd0) begin errors++; $display("FAIL loaduse_unused_src: got %b expected 0", ctl); end
        @(negedge clk); clearIn();
    endtask

    task automatic test_branch();
        @(negedge clk); clearIn();
        setLoadUse(); PCSrcM = 1; #2;
        checks++;
        if (ctl !== 8'b0000_1110) begin errors++; $display("FAIL branch_flush: got %b expected 00001110", ctl); end
        @(negedge clk); clearIn(); #2;
        checks++;
        if ({state, ctl} !== 10'b10_00000000) begin errors++; $display("FAIL branch_state_flush: got %b expected 1000000000", {state, ctl}); end
        @(negedge clk); #2;
        checks++;
        if (state !== 2'b00) begin errors++; $display("FAIL branch_state_run: got %b expected 00", state); end
    endtask

    task automatic test_mem_wait();
        @(negedge clk); clearIn();
        memReqM = 1; memReadyM = 1; #2;
        checks++;
        if (ctl !== 8'd0) begin errors++; $display("FAIL mem_zero_wait: got %b expected 0", ctl); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); memReqM = 1; memReadyM = 0; #2;
            checks++;
            if ({state, ctl} !== {(i == 0) ? 2'b00 : 2'b01, 8'b1111_0001}) begin
                errors++; $display("FAIL mem_wait_cycle%0d: got %b expected state %0d ctl 11110001", i, {state, ctl}, (i == 0) ? 0 : 1);
            end
        end
        @(negedge clk); memReadyM = 1; #2;
        checks++;
        if ({state, ctl, memErr} !== 11'b01_00000000_0) begin errors++; $display("FAIL mem_ready: got %b expected 01000000000", {state, ctl, memErr}); end
        @(negedge clk); clearIn(); #2;
        checks++;
        if (state !== 2'b00) begin errors++; $display("FAIL mem_back_to_run: got %b expected 00", state); end
    endtask

    task automatic test_watchdog();
        resetPulse();
        memReqM = 1; memReadyM = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk); #2;
            checks++;
            if (memErr !== ((k - 1) >= TO)) begin errors++; $display("FAIL watchdog_k%0d: got %b expected %0d", k, memErr, (k - 1) >= TO); end
        end
        @(negedge clk); memReadyM = 1;
        @(negedge clk); clearIn(); #2;
        checks++;
        if ({state, memErr} !== 3'b001) begin errors++; $display("FAIL watchdog_sticky: got %b expected 001", {state, memErr}); end
        @(negedge clk); memReqM = 1;
        @(negedge clk); @(negedge clk);
        reset = 0; #1;
        checks++;
        if (dutOut !== 15'd0) begin errors++; $display("FAIL reset_mid_wait: got %h expected 0", dutOut); end
        @(negedge clk); clearIn(); reset = 1;
    endtask

    task automatic test_perf();
        logic [31:0] expS, expF;
        resetPulse();
        setLoadUse();
        @(negedge clk); clearIn();
        memReqM = 1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        memReadyM = 1;
        @(negedge clk); clearIn(); PCSrcM = 1;
        @(negedge clk); clearIn(); #2;
`ifdef HAZARD_PERF_EN
        expS = 4; expF = 1;
`else
        expS = 0; expF = 0;
`endif
        checks++;
        if (stallCycles !== expS) begin errors++; $display("FAIL perf_stalls: got %0d expected %0d", stallCycles, expS); end
        checks++;
        if (flushCount !== expF) begin errors++; $display("FAIL perf_flushes: got %0d expected %0d", flushCount, expF); end
    endtask

    task automatic test_random();
        logic [14:0] e;
        logic [31:0] expS, expF;
        resetPulse();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 249) != 0);
            rs1D = RS'($urandom_range(0, 3)); rs2D = RS'($urandom_range(0, 3));
            rs1E = RS'($urandom_range(0, 3)); rs2E = RS'($urandom_range(0, 3));
            writeRegE = RS'($urandom_range(0, 3)); writeRegM = RS'($urandom_range(0, 3)); writeRegW = RS'($urandom_range(0, 3));
            {useRs1D, useRs2D, validD, regWriteE, mem2regE, validE} = 6'($urandom);
            {regWriteM, mem2regM, validM, regWriteW, validW} = 5'($urandom);
            PCSrcM = ($urandom_range(0, 7) == 0);
            memReqM = ($urandom_range(0, 3) == 0);
            memReadyM = ($urandom_range(0, 2) == 0);
            #2;
            e = expOut();
            checks++;
            if (dutOut !== e) begin errors++; $display("FAIL random_cycle%0d: got %h expected %h", n, dutOut, e); end
            if (n % 500 == 499) begin
`ifdef HAZARD_PERF_EN
                expS = mStalls; expF = mFlushes;
`else
                expS = 0; expF = 0;
`endif
                checks++;
                if (stallCycles !== expS || flushCount !== expF) begin
                    errors++; $display("FAIL random_counters%0d: got %0d/%0d expected %0d/%0d", n, stallCycles, flushCount, expS, expF);
                end
            end
        end
        @(negedge clk); reset = 1; clearIn();
    endtask

    initial begin
        clearIn();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_watchdog();
        test_perf();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
